seq_pattern_tx: RTL and testbench

- Bit-serial pattern transmitter that drives the serial line feeding the team's sequence detectors.
- Loads a PAT_W-bit pattern (default 4'b1011) and shifts it out MSB first, one bit per clk, repeated a programmable number of times.
- Uses a start/busy/done handshake.
- Exposes current_state/next_state for debug, matching the detector-side convention.

---
 rtl/seq_pkg.sv | 19 +
 rtl/seq_shift_piso.sv | 41 ++++
 rtl/seq_pattern_tx.sv | 153 +++++++++++++++
 tb/tb_seq_pattern_tx.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the sequence transmitter and the detectors it feeds.
// Holds the 2-bit FSM state encoding and the default 1011 pattern.
package seq_pkg;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_SEND = 2'b01;
   localparam logic [1:0] ST_GAP  = 2'b10;
   localparam logic [1:0] ST_DONE = 2'b11;

   localparam logic [3:0] PAT_1011 = 4'b1011;

   typedef enum logic [1:0] {
      StIdle = ST_IDLE,
      StSend = ST_SEND,
      StGap  = ST_GAP,
      StDone = ST_DONE
   } state_e;

endpackage

// File: rtl/seq_shift_piso.sv
// Parallel-in serial-out shift register, MSB first.
// Ports:
//   clk_i   - rising-edge clock
//   rst_i   - synchronous active-high reset, clears the register
//   load_i  - load data_i (has priority over shift_i)
//   shift_i - shift left by one, zero fill
//   data_i  - parallel load value
//   msb_o   - current MSB (the bit on the line)
module seq_shift_piso #(
   parameter int unsigned Width = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic             shift_i,
   input  logic [Width-1:0] data_i,
   output logic             msb_o
);

   logic [Width-1:0] shift_q, shift_d;

   always_comb begin
      shift_d = shift_q;
      if (load_i) begin
         shift_d = data_i;
      end else if (shift_i) begin
         shift_d = {shift_q[Width-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         shift_q <= '0;
      end else begin
         shift_q <= shift_d;
      end
   end

   assign msb_o = shift_q[Width-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Bit-serial pattern transmitter: captures a PAT_W-bit pattern and a repeat
// count on start, then shifts the pattern out MSB first repeat_cnt+1 times.
// Optional macro SEQ_TX_GAP_EN inserts GAP_LEN idle bits between frames.
// Ports:
//   clk_i, areset_i (synchronous, active-high)
//   start_i, use_def_i, pattern_i, repeat_cnt_i - request and its arguments
//   x_o, valid_o      - serial data and its qualifier (x_o is 0 when not valid)
//   busy_o, done_o    - handshake: busy in SEND/GAP, one-cycle done pulse
//   current_state_o, next_state_o - debug view of the FSM
module seq_pattern_tx
   import seq_pkg::*;
#(
   parameter int unsigned      PAT_W   = 4,
   parameter int unsigned      CNT_W   = 4,
   parameter int unsigned      GAP_LEN = 2,
   parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(PAT_1011)
) (
   input  logic             clk_i,
   input  logic             areset_i,
   input  logic             start_i,
   input  logic             use_def_i,
   input  logic [PAT_W-1:0] pattern_i,
   input  logic [CNT_W-1:0] repeat_cnt_i,
   output logic             x_o,
   output logic             valid_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [1:0]       current_state_o,
   output logic [1:0]       next_state_o
);

   localparam int unsigned BitW = (PAT_W > 1) ? $clog2(PAT_W) : 1;

   state_e           state_q, state_d;
   logic [BitW-1:0]  bit_cnt_q, bit_cnt_d;
   logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
   logic [CNT_W-1:0] rep_max_q, rep_max_d;
   logic [PAT_W-1:0] pat_q, pat_d;
   logic             load, shift, msb;
   logic [PAT_W-1:0] load_data;

`ifdef SEQ_TX_GAP_EN
   localparam int unsigned GapW = ($clog2(GAP_LEN + 1) > 0) ? $clog2(GAP_LEN + 1) : 1;
   logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
`endif

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      rep_cnt_d = rep_cnt_q;
      rep_max_d = rep_max_q;
      pat_d     = pat_q;
      load      = 1'b0;
      shift     = 1'b0;
      load_data = pat_q;
`ifdef SEQ_TX_GAP_EN
      gap_cnt_d = gap_cnt_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               pat_d     = use_def_i ? DEF_PAT : pattern_i;
               rep_max_d = repeat_cnt_i;
               rep_cnt_d = '0;
               bit_cnt_d = '0;
               load      = 1'b1;
               load_data = pat_d;
               state_d   = StSend;
            end
         end
         StSend: begin
            if (bit_cnt_q == BitW'(PAT_W - 1)) begin
               bit_cnt_d = '0;
               // Compare before incrementing so a max count never wraps.
               if (rep_cnt_q < rep_max_q) begin
                  rep_cnt_d = rep_cnt_q + CNT_W'(1);
                  load      = 1'b1;
`ifdef SEQ_TX_GAP_EN
                  // Pattern is preloaded here and held through the gap.
                  if (GAP_LEN > 0) begin
                     gap_cnt_d = '0;
                     state_d   = StGap;
                  end
`endif
               end else begin
                  state_d = StDone;
               end
            end else begin
               bit_cnt_d = bit_cnt_q + BitW'(1);
               shift     = 1'b1;
            end
         end
         StGap: begin
`ifdef SEQ_TX_GAP_EN
            if (gap_cnt_q == GapW'(GAP_LEN - 1)) begin
               state_d = StSend;
            end else begin
               gap_cnt_d = gap_cnt_q + GapW'(1);
            end
`else
            state_d = StIdle;
`endif
         end
         StDone: begin
            state_d = StIdle;
         end
      endcase
      if (areset_i) begin
         state_d = StIdle;
      end
   end

   always_ff @(posedge clk_i) begin
      if (areset_i) begin
         state_q   <= StIdle;
         bit_cnt_q <= '0;
         rep_cnt_q <= '0;
         rep_max_q <= '0;
         pat_q     <= '0;
`ifdef SEQ_TX_GAP_EN
         gap_cnt_q <= '0;
`endif
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         rep_cnt_q <= rep_cnt_d;
         rep_max_q <= rep_max_d;
         pat_q     <= pat_d;
`ifdef SEQ_TX_GAP_EN
         gap_cnt_q <= gap_cnt_d;
`endif
      end
   end

   seq_shift_piso #(
      .Width (PAT_W)
   ) u_piso (
      .clk_i   (clk_i),
      .rst_i   (areset_i),
      .load_i  (load),
      .shift_i (shift),
      .data_i  (load_data),
      .msb_o   (msb)
   );

   assign valid_o         = (state_q == StSend);
   assign x_o             = valid_o & msb;
   assign busy_o          = (state_q == StSend) || (state_q == StGap);
   assign done_o          = (state_q == StDone);
   assign current_state_o = state_q;
   assign next_state_o    = state_d;

endmodule

// File: tb/tb_seq_pattern_tx.sv
module tb_seq_pattern_tx;

   localparam int unsigned PatW   = 4;
   localparam int unsigned CntW   = 4;
   localparam int unsigned GapLen = 2;

   logic            clk = 1'b0;
   logic            areset, start, use_def;
   logic [PatW-1:0] pattern;
   logic [CntW-1:0] repeat_cnt;
   logic            x, valid, busy, done;
   logic [1:0]      cur_st, nxt_st;

   int n_chk = 0;
   int n_bad = 0;
   int hits;

   always #5 clk = ~clk;

   seq_pattern_tx #(
      .PAT_W   (PatW),
      .CNT_W   (CntW),
      .GAP_LEN (GapLen),
      .DEF_PAT (4'b1011)
   ) dut (
      .clk_i           (clk),
      .areset_i        (areset),
      .start_i         (start),
      .use_def_i       (use_def),
      .pattern_i       (pattern),
      .repeat_cnt_i    (repeat_cnt),
      .x_o             (x),
      .valid_o         (valid),
      .busy_o          (busy),
      .done_o          (done),
      .current_state_o (cur_st),
      .next_state_o    (nxt_st)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Step one edge and land 1 time unit after it.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Called with start already asserted; checks every frame bit, any gaps,
   // the done pulse, the return to idle and the busy cycle count.
   task automatic run_frames(input string tag, input logic [3:0] pat, input int frames,
                             output int det_hits);
      int          busy_n = 0;
      int          done_n = 0;
      logic [3:0]  sh = 4'b0000;
      det_hits = 0;
      tick;
      start = 1'b0;
      for (int f = 0; f < frames; f++) begin
         for (int b = 0; b < 4; b++) begin
            check({tag, "_x"}, 32'(x), 32'(pat[3-b]));
            check({tag, "_valid"}, 32'(valid), 32'd1);
            busy_n += int'(busy);
            done_n += int'(done);
            if (valid) begin
               sh = {sh[2:0], x};
               if (sh == 4'b1011) det_hits++;
            end
            tick;
         end
`ifdef SEQ_TX_GAP_EN
         if (f < frames - 1) begin
            for (int g = 0; g < int'(GapLen); g++) begin
               check({tag, "_gap_x"}, 32'(x), 32'd0);
               check({tag, "_gap_valid"}, 32'(valid), 32'd0);
               busy_n += int'(busy);
               done_n += int'(done);
               tick;
            end
         end
`endif
      end
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_done_busy"}, 32'(busy), 32'd0);
      check({tag, "_done_valid"}, 32'(valid), 32'd0);
      check({tag, "_done_state"}, 32'(cur_st), 32'd3);
      tick;
      check({tag, "_post_done"}, 32'(done), 32'd0);
      check({tag, "_post_state"}, 32'(cur_st), 32'd0);
`ifdef SEQ_TX_GAP_EN
      check({tag, "_busy_cycles"}, 32'(busy_n), 32'(frames * 4 + (frames - 1) * int'(GapLen)));
`else
      check({tag, "_busy_cycles"}, 32'(busy_n), 32'(frames * 4));
`endif
      check({tag, "_early_done"}, 32'(done_n), 32'd0);
   endtask

   initial begin
      areset     = 1'b1;
      start      = 1'b0;
      use_def    = 1'b0;
      pattern    = 4'b0000;
      repeat_cnt = 4'd0;
      tick;
      start = 1'b1;  // reset must override start
      tick;
      check("rst_state", 32'(cur_st), 32'd0);
      check("rst_next", 32'(nxt_st), 32'd0);
      check("rst_x", 32'(x), 32'd0);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      start  = 1'b0;
      areset = 1'b0;
      tick;
      check("idle_state", 32'(cur_st), 32'd0);

      // Single frame from the default pattern; pattern input must be ignored.
      use_def    = 1'b1;
      pattern    = 4'b0000;
      repeat_cnt = 4'd0;
      start      = 1'b1;
      #1;
      check("idle_next_send", 32'(nxt_st), 32'd1);
      run_frames("single", 4'b1011, 1, hits);
      check("single_hits", 32'(hits), 32'd1);

      // Three frames of an explicit 1011, looped into a detector model.
      use_def    = 1'b0;
      pattern    = 4'b1011;
      repeat_cnt = 4'd2;
      start      = 1'b1;
      run_frames("repeat", 4'b1011, 3, hits);
      check("repeat_hits", 32'(hits), 32'd3);

      // Busy guard: start pulsed mid-frame with new arguments and again in DONE.
      pattern    = 4'b1011;
      repeat_cnt = 4'd0;
      start      = 1'b1;
      tick;
      start = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         check("guard_x", 32'(x), 32'(c == 2 ? 1'b0 : 1'b1));
         check("guard_valid", 32'(valid), 32'd1);
         if (c == 2) begin
            start      = 1'b1;
            pattern    = 4'b0000;
            repeat_cnt = 4'd5;
         end else begin
            start = 1'b0;
         end
         tick;
      end
      check("guard_done", 32'(done), 32'd1);
      start = 1'b1;
      #1;
      check("guard_done_next", 32'(nxt_st), 32'd0);
      tick;
      start = 1'b0;
      check("guard_idle", 32'(cur_st), 32'd0);
      check("guard_idle_busy", 32'(busy), 32'd0);
      tick;
      check("guard_idle2", 32'(cur_st), 32'd0);
      pattern    = 4'b1101;
      repeat_cnt = 4'd0;
      start      = 1'b1;
      run_frames("guard_new", 4'b1101, 1, hits);

      // Reset mid-frame after the second bit.
      pattern    = 4'b1011;
      repeat_cnt = 4'd3;
      start      = 1'b1;
      tick;
      start = 1'b0;
      check("midrst_b0", 32'(x), 32'd1);
      tick;
      check("midrst_b1", 32'(x), 32'd0);
      areset = 1'b1;
      #1;
      check("midrst_next", 32'(nxt_st), 32'd0);
      tick;
      check("midrst_state", 32'(cur_st), 32'd0);
      check("midrst_x", 32'(x), 32'd0);
      check("midrst_valid", 32'(valid), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      areset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick;
         check("midrst_nodone", 32'(done), 32'd0);
         check("midrst_nobusy", 32'(busy), 32'd0);
      end
      use_def    = 1'b1;
      repeat_cnt = 4'd0;
      start      = 1'b1;
      run_frames("midrst_fresh", 4'b1011, 1, hits);

      // Maximum repeat count with a custom pattern: 16 frames of 0110.
      use_def    = 1'b0;
      pattern    = 4'b0110;
      repeat_cnt = 4'd15;
      start      = 1'b1;
      run_frames("maxcnt", 4'b0110, 16, hits);
      check("maxcnt_hits", 32'(hits), 32'd0);

      // Two frames; exercises the gap path when it is compiled in.
      pattern    = 4'b1011;
      repeat_cnt = 4'd1;
      start      = 1'b1;
      run_frames("two", 4'b1011, 2, hits);
      check("two_hits", 32'(hits), 32'd2);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
